// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for register read/write frames: a 9-bit header, optional dummy bits,
// then 8/16/32 data bits. It takes one command per chip-select frame and pulses a response at frame end.
module spi_reg_master #(
  parameter int ADDR_W     = 6,
  parameter int CLK_DIV    = 4,
  parameter int READ_DUMMY = 1,
  parameter int CS_IDLE    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_width,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int         HDR      = 3 + ADDR_W;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LO, S_HI, S_HOLD, S_END, S_GAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [5:0]  bit_cnt, bit_nxt;
  logic [63:0] tx_sr, tx_nxt, tx_load;
  logic [31:0] rx_sr, rx_nxt, rdata_nxt;
  logic        rw_q, rw_nxt;
  logic [1:0]  width_q, width_nxt;
  logic        ready_nxt, rsp_valid_nxt, cs_n_nxt, sclk_nxt, mosi_nxt;
  logic        div_wrap;

  function automatic int data_bits(input logic [1:0] w);
    case (w)
      2'b00:   return 8;
      2'b01:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] data_mask(input logic [1:0] w);
    case (w)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign busy = (state != S_IDLE);

  // NOTE: every variable gets a default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt     = state;
    div_nxt       = div_cnt;
    bit_nxt       = bit_cnt;
    tx_nxt        = tx_sr;
    rx_nxt        = rx_sr;
    rw_nxt        = rw_q;
    width_nxt     = width_q;
    ready_nxt     = 1'b0;
    rsp_valid_nxt = 1'b0;
    rdata_nxt     = rsp_rdata;
    cs_n_nxt      = spi_cs_n;
    sclk_nxt      = spi_clk;
    mosi_nxt      = spi_mosi;
    div_wrap      = (div_cnt == DIV_LAST);
    // Whole frame left-aligned so mosi always comes from bit 63; read frames shift out zeros.
    tx_load = {cmd_rw, cmd_width, cmd_addr, {(64 - HDR){1'b0}}};
    if (cmd_rw)
      tx_load = tx_load | (({cmd_wdata, 32'h0} << (32 - data_bits(cmd_width))) >> HDR);

    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_nxt = S_SETUP;
          ready_nxt = 1'b0;
          div_nxt   = 8'd0;
          bit_nxt   = 6'(HDR + (cmd_rw ? 0 : READ_DUMMY) + data_bits(cmd_width) - 1);
          tx_nxt    = tx_load;
          rw_nxt    = cmd_rw;
          width_nxt = cmd_width;
          cs_n_nxt  = 1'b0;
          sclk_nxt  = 1'b0;
          mosi_nxt  = 1'b0;
        end
      end
      S_SETUP: begin
        if (div_wrap) begin
          state_nxt = S_LO;
          div_nxt   = 8'd0;
          mosi_nxt  = tx_sr[63];
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      S_LO: begin
        if (div_wrap) begin
          state_nxt = S_HI;
          div_nxt   = 8'd0;
          sclk_nxt  = 1'b1;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      S_HI: begin
        if (div_wrap) begin
          rx_nxt   = {rx_sr[30:0], spi_miso};
          div_nxt  = 8'd0;
          sclk_nxt = 1'b0;
          if (bit_cnt == 6'd0) begin
            state_nxt = S_HOLD;
            mosi_nxt  = 1'b0;
          end else begin
            state_nxt = S_LO;
            bit_nxt   = bit_cnt - 6'd1;
            tx_nxt    = {tx_sr[62:0], 1'b0};
            mosi_nxt  = tx_sr[62];
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (div_wrap) begin
          state_nxt     = S_END;
          div_nxt       = 8'd0;
          cs_n_nxt      = 1'b1;
          rsp_valid_nxt = 1'b1;
          // Only the last D sampled bits are data; header/dummy samples fall off or get masked.
          if (!rw_q) rdata_nxt = rx_sr & data_mask(width_q);
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      S_END: begin
        div_nxt = 8'd0;
        if (CS_IDLE <= 1) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (div_cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 6'd0;
      tx_sr     <= 64'd0;
      rx_sr     <= 32'd0;
      rw_q      <= 1'b0;
      width_q   <= 2'b00;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      spi_cs_n  <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      tx_sr     <= tx_nxt;
      rx_sr     <= rx_nxt;
      rw_q      <= rw_nxt;
      width_q   <= width_nxt;
      cmd_ready <= ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rdata_nxt;
      spi_cs_n  <= cs_n_nxt;
      spi_clk   <= sclk_nxt;
      spi_mosi  <= mosi_nxt;
    end
  end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- SPI initiator that issues register read/write transactions to the peripheral-harness SPI register responder (ADDR_W=6, REG_W=32).
- Used in on-chip self-test and in bench harnesses to drive the harness SPI pins (cs_n, clk, mosi, miso) from a simple valid/ready command port.
- Serialises one command per chip-select frame and returns the read data on a one-cycle response strobe.

Parameters:
ADDR_W, 6, register address width
CLK_DIV, 4, clk cycles per spi_clk half-period; legal values are 2..255
READ_DUMMY, 1, spi_clk cycles between header and read data, with mosi held at 0
CS_IDLE, 4, minimum clk cycles cs_n stays high between frames

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  master can accept a command
cmd_rw  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  register address
cmd_width  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = treated as 32-bit
cmd_wdata  in  32  write data; only the low D bits are sent
rsp_valid  out  1  one-cycle pulse at frame end, for both reads and writes
rsp_rdata  out  32  read data, zero-extended; held until the next rsp_valid
busy  out  1  frame in progress (state not IDLE)
spi_cs_n  out  1  chip select, active low
spi_clk  out  1  SPI clock, mode 0 (idles low)
spi_mosi  out  1  serial data to responder
spi_miso  in  1  serial data from responder, already synchronised externally

Behaviour:
- Reset (synchronous, rst=1 on a clk edge):
  - spi_cs_n=1, spi_clk=0, spi_mosi=0.
  - cmd_ready=0 for the cycle after reset, then 1.
  - rsp_valid=0, rsp_rdata=0, busy=0.
  - Reset applied mid-frame aborts the frame the next cycle: cs_n high, clk low, no rsp_valid.
- All SPI outputs are registered.
- Command acceptance:
  - A command is accepted on a cycle with cmd_valid & cmd_ready (call it T).
  - All cmd_* fields are latched at T; cmd_ready drops at T+1.
- Frame format, MSB first:
  - Header: rw, width[1], width[0], addr[ADDR_W-1:0] (9 bits).
  - Write frames: D data bits follow the header. D = 8, 16 or 32 from cmd_width.
  - Read frames: READ_DUMMY dummy bits, then D bits sampled from miso.
  - Bit count N = 9 + D for writes; N = 9 + READ_DUMMY + D for reads.
- States:
  - IDLE: cmd_ready=1; leave on accept.
  - SETUP: cs_n low from T+1 for CLK_DIV cycles, spi_clk low.
  - SHIFT: N bits. Each bit is CLK_DIV cycles clk-low, then CLK_DIV cycles clk-high.
    - mosi updates on the first cycle of the low phase (falling edge or SETUP end), so the responder samples on the rising edge.
    - miso is sampled on the last clk cycle of the high phase and shifted in MSB first.
    - mosi is 0 during dummy and read-data bits.
  - HOLD: spi_clk low, cs_n still low, for CLK_DIV cycles.
  - END: cs_n high and rsp_valid=1 for one cycle at T+1+2*CLK_DIV*(N+1); rsp_rdata updates on the same cycle (reads only; writes leave it unchanged).
  - GAP: cs_n high for CS_IDLE cycles, counted from the END cycle inclusive, then IDLE with cmd_ready=1.
- Counters:
  - Divider counter is 8-bit, wraps at CLK_DIV-1.
  - Bit counter is 6-bit, counts down from N-1; the frame ends at 0 after the high phase.
- Back-to-back commands: cmd_valid held high is accepted on the first IDLE cycle; no combinational path from cmd_valid to cmd_ready.
- Read data width: 8/16-bit reads place the received bits in rsp_rdata[D-1:0], with the upper bits 0.

Test Plan:
- Write, CLK_DIV=2, width=00, addr=0x05, wdata=0x123456A5, accept at T:
  - mosi sampled at rising edges = 1,0,0,000101,10100101 (17 edges).
  - cs_n rises and rsp_valid pulses at T+73; cmd_ready returns at T+77 (CS_IDLE=4).
- Read, width=10, addr=0x3F, READ_DUMMY=1, miso model returns 0xDEADBEEF after the dummy bit:
  - header seen = 0,10,111111; mosi=0 afterwards.
  - rsp_rdata = 0xDEADBEEF, N = 42.
- Read, width=00, miso returns 0xC3: rsp_rdata = 0x000000C3. A following write leaves rsp_rdata at 0x000000C3.
- width=11 write, wdata=0xCAFEF00D: 32 data bits sent (N=41), header width bits 1,1.
- Back-to-back, cmd_valid held for 3 writes:
  - exactly 3 cs_n low frames, each separated by ≥ CS_IDLE high cycles;
  - 3 rsp_valid pulses, with no command dropped or duplicated.
- rst asserted for 1 cycle at the 10th spi_clk rising edge of a read:
  - next cycle: cs_n=1, spi_clk=0, mosi=0, no rsp_valid, rsp_rdata=0;
  - a new command after reset completes normally.
